// File: rtl/xm_mem_interface.sv
// rtl/xm_mem_interface.sv - X-Makina memory bus interface stage with byte steering, alignment check and bus timeout
//
// Purpose: accepts one access request per instruction step from the datapath
// and runs it on a word-wide external bus with a req/ack handshake.
// Ports:
//   clk_i, arst_i            clock, synchronous active-high reset
//   req_i, wr_i, byte_i      access request, direction, byte/word size
//   addr_i, wdata_i          byte address (MAR) and write data (OMDR)
//   badMem_i                 illegal-address flag from the address decoder
//   bus_req_o .. bus_ack_i   external word bus (registered outputs)
//   rdata_o                  read result for IMDR/IR
//   done_o, fault_o, busy_o  completion pulse, fault code, access in progress

module xm_mem_interface #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            req_i,
    input  logic            wr_i,
    input  logic            byte_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    input  logic            badMem_i,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [WORD-2:0] bus_addr_o,
    output logic [1:0]      bus_be_o,
    output logic [WORD-1:0] bus_wdata_o,
    input  logic [WORD-1:0] bus_rdata_i,
    input  logic            bus_ack_i,
    output logic [WORD-1:0] rdata_o,
    output logic            done_o,
    output logic [1:0]      fault_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       byte_q;
    logic       lsb_q;
    logic [1:0] acc_fault;
    logic       bus_end;

    // Fault code for the request currently on the inputs; bad address wins
    // over misalignment.
    always_comb begin
        acc_fault = 2'b00;
        if (badMem_i) begin
            acc_fault = 2'b01;
        end else if (!byte_i && addr_i[0]) begin
            acc_fault = 2'b10;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_nxt = (acc_fault != 2'b00) ? DONE : BUS;
                end
            end
            BUS: begin
                // Ack in the final timeout cycle still counts as success.
                if (bus_ack_i || (cnt == LAST_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus_end = (state == BUS) && (state_nxt == DONE);

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            cnt         <= '0;
            byte_q      <= 1'b0;
            lsb_q       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 2'b00;
            bus_wdata_o <= '0;
            rdata_o     <= '0;
            fault_o     <= 2'b00;
        end else begin
            if (state == IDLE && req_i) begin
                byte_q  <= byte_i;
                lsb_q   <= addr_i[0];
                cnt     <= '0;
                fault_o <= acc_fault;
                if (acc_fault == 2'b00) begin
                    bus_req_o  <= 1'b1;
                    bus_we_o   <= wr_i;
                    bus_addr_o <= addr_i[WORD-1:1];
                    if (byte_i) begin
                        bus_be_o    <= addr_i[0] ? 2'b10 : 2'b01;
                        // Low byte goes out on both lanes; be selects the live one.
                        bus_wdata_o <= {(WORD/8){wdata_i[7:0]}};
                    end else begin
                        bus_be_o    <= 2'b11;
                        bus_wdata_o <= wdata_i;
                    end
                end
            end

            if (state == BUS) begin
                if (bus_ack_i) begin
                    fault_o <= 2'b00;
                    if (!bus_we_o) begin
                        if (!byte_q) begin
                            rdata_o <= bus_rdata_i;
                        end else if (lsb_q) begin
                            rdata_o <= {{(WORD-8){1'b0}}, bus_rdata_i[15:8]};
                        end else begin
                            rdata_o <= {{(WORD-8){1'b0}}, bus_rdata_i[7:0]};
                        end
                    end
                end else if (cnt == LAST_CNT) begin
                    fault_o <= 2'b11;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end

            if (bus_end) begin
                bus_req_o   <= 1'b0;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= '0;
                bus_be_o    <= 2'b00;
                bus_wdata_o <= '0;
            end
        end
    end

    assign done_o = (state == DONE);
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_xm_mem_interface.sv
// tb/tb_xm_mem_interface.sv - directed self-checking bench for xm_mem_interface

module tb_xm_mem_interface;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        req_i;
    logic        wr_i;
    logic        byte_s;
    logic [15:0] addr_i;
    logic [15:0] wdata_i;
    logic        bad_mem;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [14:0] bus_addr_o;
    logic [1:0]  bus_be_o;
    logic [15:0] bus_wdata_o;
    logic [15:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [15:0] rdata_o;
    logic        done_o;
    logic [1:0]  fault_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    xm_mem_interface #(.WORD(16), .TIMEOUT(15)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_i       (req_i),
        .wr_i        (wr_i),
        .byte_i      (byte_s),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .badMem_i    (bad_mem),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .fault_o     (fault_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic w, input logic b, input logic [15:0] a,
                         input logic [15:0] d, input logic bad);
        req_i   = 1'b1;
        wr_i    = w;
        byte_s  = b;
        addr_i  = a;
        wdata_i = d;
        bad_mem = bad;
        tick();
        req_i   = 1'b0;
        bad_mem = 1'b0;
    endtask

    task automatic test_reset();
        arst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_o, done_o, fault_o, busy_o} !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rd=%h done=%b fault=%b busy=%b, expected all 0",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_o, done_o, fault_o, busy_o);
        end
        arst_i = 1'b0;
        tick();
    endtask

    task automatic test_word_read();
        issue(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0);
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, busy_o, done_o} !== {1'b1, 1'b0, 15'h091A, 2'b11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL word_read_bus: got req=%b we=%b addr=%h be=%b busy=%b done=%b, expected 1 0 091a 11 1 0",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, busy_o, done_o);
        end
        tick();
        tick();
        checks++;
        if ({bus_req_o, bus_addr_o, done_o} !== {1'b1, 15'h091A, 1'b0}) begin
            errors++;
            $display("FAIL word_read_wait: got req=%b addr=%h done=%b, expected 1 091a 0", bus_req_o, bus_addr_o, done_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'hBEEF;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 16'h0000;
        checks++;
        if ({done_o, rdata_o, fault_o, bus_req_o} !== {1'b1, 16'hBEEF, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL word_read_done: got done=%b rdata=%h fault=%b req=%b, expected 1 beef 00 0",
                     done_o, rdata_o, fault_o, bus_req_o);
        end
        tick();
        checks++;
        if ({done_o, busy_o, rdata_o} !== {1'b0, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL word_read_idle: got done=%b busy=%b rdata=%h, expected 0 0 beef", done_o, busy_o, rdata_o);
        end
    endtask

    task automatic test_byte_read();
        logic [15:0] addrs [2];
        logic [1:0]  bes   [2];
        logic [15:0] exps  [2];
        addrs[0] = 16'h0011; bes[0] = 2'b10; exps[0] = 16'h00A5;
        addrs[1] = 16'h0010; bes[1] = 2'b01; exps[1] = 16'h005A;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 1'b1, addrs[i], 16'h0000, 1'b0);
            checks++;
            if ({bus_req_o, bus_be_o, bus_addr_o} !== {1'b1, bes[i], 15'h0008}) begin
                errors++;
                $display("FAIL byte_read_bus[%0d]: got req=%b be=%b addr=%h, expected 1 %b 0008",
                         i, bus_req_o, bus_be_o, bus_addr_o, bes[i]);
            end
            bus_ack_i   = 1'b1;
            bus_rdata_i = 16'hA55A;
            tick();
            bus_ack_i   = 1'b0;
            checks++;
            if ({done_o, rdata_o, fault_o} !== {1'b1, exps[i], 2'b00}) begin
                errors++;
                $display("FAIL byte_read_data[%0d]: got done=%b rdata=%h fault=%b, expected 1 %h 00",
                         i, done_o, rdata_o, fault_o, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_byte_write();
        issue(1'b1, 1'b1, 16'h0021, 16'h12C3, 1'b0);
        checks++;
        if ({bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o} !== {1'b1, 1'b1, 2'b10, 16'hC3C3, 15'h0010}) begin
            errors++;
            $display("FAIL byte_write_bus: got req=%b we=%b be=%b wdata=%h addr=%h, expected 1 1 10 c3c3 0010",
                     bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL byte_write_early_done: got done=%b, expected 0", done_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'hFFFF;
        tick();
        bus_ack_i   = 1'b0;
        checks++;
        if ({done_o, rdata_o, fault_o, bus_we_o} !== {1'b1, 16'h005A, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL byte_write_done: got done=%b rdata=%h fault=%b we=%b, expected 1 005a 00 0",
                     done_o, rdata_o, fault_o, bus_we_o);
        end
        tick();
    endtask

    task automatic test_faults();
        issue(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
        checks++;
        if ({done_o, fault_o, bus_req_o} !== {1'b1, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL misaligned: got done=%b fault=%b req=%b, expected 1 10 0", done_o, fault_o, bus_req_o);
        end
        tick();
        checks++;
        if ({done_o, busy_o, fault_o, bus_req_o} !== {1'b0, 1'b0, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL misaligned_hold: got done=%b busy=%b fault=%b req=%b, expected 0 0 10 0",
                     done_o, busy_o, fault_o, bus_req_o);
        end
        issue(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1);
        checks++;
        if ({done_o, fault_o, bus_req_o, rdata_o} !== {1'b1, 2'b01, 1'b0, 16'h005A}) begin
            errors++;
            $display("FAIL bad_addr_priority: got done=%b fault=%b req=%b rdata=%h, expected 1 01 0 005a",
                     done_o, fault_o, bus_req_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0);
        n = 0;
        while (bus_req_o && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, expected 15", n);
        end
        checks++;
        if ({done_o, fault_o, rdata_o} !== {1'b1, 2'b11, 16'h005A}) begin
            errors++;
            $display("FAIL timeout_fault: got done=%b fault=%b rdata=%h, expected 1 11 005a", done_o, fault_o, rdata_o);
        end
        tick();
        issue(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0);
        repeat (14) tick();
        checks++;
        if ({bus_req_o, done_o} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_last_cycle: got req=%b done=%b, expected 1 0", bus_req_o, done_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'h7777;
        tick();
        bus_ack_i   = 1'b0;
        checks++;
        if ({done_o, fault_o, rdata_o} !== {1'b1, 2'b00, 16'h7777}) begin
            errors++;
            $display("FAIL ack_wins_timeout: got done=%b fault=%b rdata=%h, expected 1 00 7777", done_o, fault_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0);
        req_i  = 1'b1;
        addr_i = 16'h0200;
        tick();
        req_i  = 1'b0;
        checks++;
        if ({bus_req_o, bus_addr_o, busy_o} !== {1'b1, 15'h0080, 1'b1}) begin
            errors++;
            $display("FAIL req_while_busy: got req=%b addr=%h busy=%b, expected 1 0080 1", bus_req_o, bus_addr_o, busy_o);
        end
        arst_i = 1'b1;
        tick();
        arst_i = 1'b0;
        checks++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_o, done_o, fault_o, busy_o} !== 55'd0) begin
            errors++;
            $display("FAIL mid_bus_reset: got req=%b we=%b addr=%h be=%b wd=%h rd=%h done=%b fault=%b busy=%b, expected all 0",
                     bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, rdata_o, done_o, fault_o, busy_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'hDEAD;
        tick();
        bus_ack_i   = 1'b0;
        checks++;
        if ({done_o, rdata_o, fault_o, busy_o, bus_req_o} !== {1'b0, 16'h0000, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stray_ack: got done=%b rdata=%h fault=%b busy=%b req=%b, expected 0 0000 00 0 0",
                     done_o, rdata_o, fault_o, busy_o, bus_req_o);
        end
        tick();
        checks++;
        if ({busy_o, done_o, bus_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL req_not_queued: got busy=%b done=%b req=%b, expected 0 0 0", busy_o, done_o, bus_req_o);
        end
    endtask

    initial begin
        arst_i      = 1'b1;
        req_i       = 1'b0;
        wr_i        = 1'b0;
        byte_s      = 1'b0;
        addr_i      = 16'h0000;
        wdata_i     = 16'h0000;
        bad_mem     = 1'b0;
        bus_rdata_i = 16'h0000;
        bus_ack_i   = 1'b0;

        test_reset();
        test_word_read();
        test_byte_read();
        test_byte_write();
        test_faults();
        test_timeout();
        test_reset_mid_bus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
